// File: rtl/lc3_pkg.sv
// Shared LC-3 definitions: opcodes, ALU codes, E_Control field layout,
// pcselect1 encodings and the sign-extension helper.
package lc3_pkg;

  localparam logic [3:0] OP_BR  = 4'b0000;
  localparam logic [3:0] OP_ADD = 4'b0001;
  localparam logic [3:0] OP_LD  = 4'b0010;
  localparam logic [3:0] OP_ST  = 4'b0011;
  localparam logic [3:0] OP_AND = 4'b0101;
  localparam logic [3:0] OP_LDR = 4'b0110;
  localparam logic [3:0] OP_STR = 4'b0111;
  localparam logic [3:0] OP_NOT = 4'b1001;
  localparam logic [3:0] OP_LDI = 4'b1010;
  localparam logic [3:0] OP_STI = 4'b1011;
  localparam logic [3:0] OP_JMP = 4'b1100;
  localparam logic [3:0] OP_LEA = 4'b1110;

  localparam logic [1:0] ALU_ADD  = 2'b00;
  localparam logic [1:0] ALU_AND  = 2'b01;
  localparam logic [1:0] ALU_NOT  = 2'b10;
  localparam logic [1:0] ALU_RSVD = 2'b11;

  // E_Control = {alu_control[1:0], pcselect1[1:0], pcselect2, op2select}
  localparam int EC_ALU_HI  = 5;
  localparam int EC_ALU_LO  = 4;
  localparam int EC_PCS1_HI = 3;
  localparam int EC_PCS1_LO = 2;
  localparam int EC_PCS2    = 1;
  localparam int EC_OP2SEL  = 0;

  localparam logic [1:0] PCS1_OFF11 = 2'b00;
  localparam logic [1:0] PCS1_OFF9  = 2'b01;
  localparam logic [1:0] PCS1_OFF6  = 2'b10;
  localparam logic [1:0] PCS1_ZERO  = 2'b11;

  // Sign-extend the low 'bits' bits of val to 16 bits (bits in 1..16).
  function automatic logic [15:0] sext16(input logic [15:0] val, input logic [4:0] bits);
    logic signed [15:0] t;
    t = $signed(val << (5'd16 - bits));
    return t >>> (5'd16 - bits);
  endfunction

endpackage

// File: rtl/lc3_exec_alu.sv
// Combinational LC-3 ALU: ADD, AND, NOT; reserved code yields zero.
module lc3_exec_alu
  import lc3_pkg::*;
(
  input  logic [15:0] VSR1,
  input  logic [15:0] op2,
  input  logic [1:0]  alu_control,
  output logic [15:0] result
);

  // Select the operation; carry out of ADD is dropped.
  always_comb begin
    result = 16'h0000;
    case (alu_control)
      ALU_ADD:  result = VSR1 + op2;
      ALU_AND:  result = VSR1 & op2;
      ALU_NOT:  result = ~VSR1;
      ALU_RSVD: result = 16'h0000;
      default:  result = 16'h0000;
    endcase
  end

endmodule

// File: rtl/lc3_execute_stage.sv
// LC-3 execute stage: operand select, ALU, address generation and the
// one-cycle output register bank toward memory and writeback.
module lc3_execute_stage
  import lc3_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable_execute,
  input  logic [5:0]       E_Control,
  input  logic [1:0]       W_Control_in,
  input  logic             Mem_Control_in,
  input  logic [WIDTH-1:0] IR,
  input  logic [WIDTH-1:0] npc_in,
  input  logic [WIDTH-1:0] VSR1,
  input  logic [WIDTH-1:0] VSR2,
  output logic [2:0]       sr1,
  output logic [2:0]       sr2,
  output logic [WIDTH-1:0] aluout,
  output logic [WIDTH-1:0] pcout,
  output logic [WIDTH-1:0] M_Data,
  output logic [2:0]       dr,
  output logic [2:0]       NZP,
  output logic [WIDTH-1:0] IR_Exec,
  output logic [1:0]       W_Control_out,
  output logic             Mem_Control_out,
  output logic             out_valid
);

  logic [3:0]       opcode;
  logic             is_alu;
  logic             is_store;
  logic             writes_dr;
  logic [WIDTH-1:0] op2;
  logic [WIDTH-1:0] offset;
  logic [WIDTH-1:0] base;
  logic [WIDTH-1:0] addr;
  logic [WIDTH-1:0] alu_res;
  logic [2:0]       dr_c;
  logic [2:0]       nzp_c;

  logic [WIDTH-1:0] aluout_q, aluout_d;
  logic [WIDTH-1:0] pcout_q, pcout_d;
  logic [WIDTH-1:0] m_data_q, m_data_d;
  logic [2:0]       dr_q, dr_d;
  logic [2:0]       nzp_q, nzp_d;
  logic [WIDTH-1:0] ir_exec_q, ir_exec_d;
  logic [1:0]       w_control_q, w_control_d;
  logic             mem_control_q, mem_control_d;
  logic             out_valid_q, out_valid_d;

  // Instruction class decode and register-file read addresses.
  always_comb begin
    opcode    = IR[15:12];
    is_alu    = (opcode == OP_ADD) || (opcode == OP_AND) || (opcode == OP_NOT);
    is_store  = (opcode == OP_ST) || (opcode == OP_STR) || (opcode == OP_STI);
    writes_dr = is_alu || (opcode == OP_LD) || (opcode == OP_LDR) ||
                (opcode == OP_LDI) || (opcode == OP_LEA);
    sr1       = IR[8:6];
    sr2       = is_store ? IR[11:9] : IR[2:0];
    dr_c      = writes_dr ? IR[11:9] : 3'b000;
    nzp_c     = (opcode == OP_BR)  ? IR[11:9] :
                (opcode == OP_JMP) ? 3'b111 : 3'b000;
  end

  // Second ALU operand and base+offset address generation.
  always_comb begin
    op2 = E_Control[EC_OP2SEL] ? VSR2 : sext16({11'b0, IR[4:0]}, 5'd5);
    offset = '0;
    case (E_Control[EC_PCS1_HI:EC_PCS1_LO])
      PCS1_OFF11: offset = sext16({5'b0, IR[10:0]}, 5'd11);
      PCS1_OFF9:  offset = sext16({7'b0, IR[8:0]}, 5'd9);
      PCS1_OFF6:  offset = sext16({10'b0, IR[5:0]}, 5'd6);
      PCS1_ZERO:  offset = '0;
      default:    offset = '0;
    endcase
    base = E_Control[EC_PCS2] ? npc_in : VSR1;
    addr = base + offset;
  end

  lc3_exec_alu u_alu (
    .VSR1        (VSR1),
    .op2         (op2),
    .alu_control (E_Control[EC_ALU_HI:EC_ALU_LO]),
    .result      (alu_res)
  );

  // Next register values: load on enable, otherwise hold; valid pulses per load.
  always_comb begin
    aluout_d      = aluout_q;
    pcout_d       = pcout_q;
    m_data_d      = m_data_q;
    dr_d          = dr_q;
    nzp_d         = nzp_q;
    ir_exec_d     = ir_exec_q;
    w_control_d   = w_control_q;
    mem_control_d = mem_control_q;
    out_valid_d   = enable_execute;
    if (enable_execute) begin
      aluout_d      = is_alu ? alu_res : addr;
      pcout_d       = addr;
      m_data_d      = VSR2;
      dr_d          = dr_c;
      nzp_d         = nzp_c;
      ir_exec_d     = IR;
      w_control_d   = W_Control_in;
      mem_control_d = Mem_Control_in;
    end
  end

  // Output registers with synchronous active-low clear taking priority.
  always_ff @(posedge clock) begin
    if (!reset) begin
      aluout_q      <= '0;
      pcout_q       <= '0;
      m_data_q      <= '0;
      dr_q          <= '0;
      nzp_q         <= '0;
      ir_exec_q     <= '0;
      w_control_q   <= '0;
      mem_control_q <= 1'b0;
      out_valid_q   <= 1'b0;
    end else begin
      aluout_q      <= aluout_d;
      pcout_q       <= pcout_d;
      m_data_q      <= m_data_d;
      dr_q          <= dr_d;
      nzp_q         <= nzp_d;
      ir_exec_q     <= ir_exec_d;
      w_control_q   <= w_control_d;
      mem_control_q <= mem_control_d;
      out_valid_q   <= out_valid_d;
    end
  end

  assign aluout          = aluout_q;
  assign pcout           = pcout_q;
  assign M_Data          = m_data_q;
  assign dr              = dr_q;
  assign NZP             = nzp_q;
  assign IR_Exec         = ir_exec_q;
  assign W_Control_out   = w_control_q;
  assign Mem_Control_out = mem_control_q;
  assign out_valid       = out_valid_q;

endmodule

// File: tb/tb_lc3_execute_stage.sv
// Self-checking bench for lc3_execute_stage: directed cases with literal
// expectations plus randomized traffic against a behavioural model.
module tb_lc3_execute_stage;

  logic        clock = 1'b0;
  logic        reset;
  logic        enable_execute;
  logic [5:0]  E_Control;
  logic [1:0]  W_Control_in;
  logic        Mem_Control_in;
  logic [15:0] IR, npc_in, VSR1, VSR2;
  logic [2:0]  sr1, sr2, dr, NZP;
  logic [15:0] aluout, pcout, M_Data, IR_Exec;
  logic [1:0]  W_Control_out;
  logic        Mem_Control_out, out_valid;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [15:0] alu;
    logic [15:0] pc;
    logic [15:0] md;
    logic [2:0]  dr;
    logic [2:0]  nzp;
    logic [15:0] ir;
    logic [1:0]  wc;
    logic        mc;
  } res_t;

  res_t exp_r;
  logic exp_valid;
  logic model_ok = 1'b0;

  lc3_execute_stage #(.WIDTH(16)) dut (
    .clock           (clock),
    .reset           (reset),
    .enable_execute  (enable_execute),
    .E_Control       (E_Control),
    .W_Control_in    (W_Control_in),
    .Mem_Control_in  (Mem_Control_in),
    .IR              (IR),
    .npc_in          (npc_in),
    .VSR1            (VSR1),
    .VSR2            (VSR2),
    .sr1             (sr1),
    .sr2             (sr2),
    .aluout          (aluout),
    .pcout           (pcout),
    .M_Data          (M_Data),
    .dr              (dr),
    .NZP             (NZP),
    .IR_Exec         (IR_Exec),
    .W_Control_out   (W_Control_out),
    .Mem_Control_out (Mem_Control_out),
    .out_valid       (out_valid)
  );

  always #5 clock = ~clock;

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, expv, $time);
    end
  endtask

  // Behavioural model: integer arithmetic on signed field values.
  function automatic res_t model(input logic [15:0] ir, input logic [5:0] ec,
                                 input logic [15:0] npc, input logic [15:0] v1,
                                 input logic [15:0] v2, input logic [1:0] wc,
                                 input logic mc);
    res_t r;
    int imm5, opnd, alu, off, base;
    int op;
    op   = int'(ir[15:12]);
    imm5 = int'(ir[4:0]);
    if (ir[4]) imm5 -= 32;
    opnd = ec[0] ? int'(v2) : imm5;
    case (ec[5:4])
      2'd0:    alu = int'(v1) + opnd;
      2'd1:    alu = int'(v1) & opnd;
      2'd2:    alu = ~int'(v1);
      default: alu = 0;
    endcase
    case (ec[3:2])
      2'd0:    begin off = int'(ir[10:0]); if (ir[10]) off -= 2048; end
      2'd1:    begin off = int'(ir[8:0]);  if (ir[8])  off -= 512;  end
      2'd2:    begin off = int'(ir[5:0]);  if (ir[5])  off -= 64;   end
      default: off = 0;
    endcase
    base  = ec[1] ? int'(npc) : int'(v1);
    r.pc  = 16'(base + off);
    r.alu = (op == 1 || op == 5 || op == 9) ? 16'(alu) : r.pc;
    r.md  = v2;
    r.dr  = (op inside {1, 5, 9, 2, 6, 10, 14}) ? ir[11:9] : 3'd0;
    r.nzp = (op == 0) ? ir[11:9] : (op == 12) ? 3'b111 : 3'b000;
    r.ir  = ir;
    r.wc  = wc;
    r.mc  = mc;
    return r;
  endfunction

  // Model register: mirrors the load/hold/clear behaviour at each edge.
  always @(posedge clock) begin
    if (!reset) begin
      exp_r     <= '0;
      exp_valid <= 1'b0;
      model_ok  <= 1'b1;
    end else if (enable_execute) begin
      exp_r     <= model(IR, E_Control, npc_in, VSR1, VSR2, W_Control_in, Mem_Control_in);
      exp_valid <= 1'b1;
    end else begin
      exp_valid <= 1'b0;
    end
  end

  // Compare every registered output and the read addresses each cycle.
  always @(posedge clock) begin
    #1;
    if (model_ok) begin
      chk("aluout", aluout, exp_r.alu);
      chk("pcout", pcout, exp_r.pc);
      chk("M_Data", M_Data, exp_r.md);
      chk("dr", 16'(dr), 16'(exp_r.dr));
      chk("NZP", 16'(NZP), 16'(exp_r.nzp));
      chk("IR_Exec", IR_Exec, exp_r.ir);
      chk("W_Control_out", 16'(W_Control_out), 16'(exp_r.wc));
      chk("Mem_Control_out", 16'(Mem_Control_out), 16'(exp_r.mc));
      chk("out_valid", 16'(out_valid), 16'(exp_valid));
      chk("sr1", 16'(sr1), 16'(IR[8:6]));
      chk("sr2", 16'(sr2), 16'((IR[15:12] inside {4'd3, 4'd7, 4'd11}) ? IR[11:9] : IR[2:0]));
    end
  end

  task automatic randomize_inputs();
    logic [3:0] ops [12] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd5, 4'd6, 4'd7,
                             4'd9, 4'd10, 4'd11, 4'd12, 4'd14};
    IR             = {ops[$urandom_range(0, 11)], 12'($urandom)};
    E_Control      = 6'($urandom);
    W_Control_in   = 2'($urandom);
    Mem_Control_in = 1'($urandom);
    npc_in         = 16'($urandom);
    VSR1           = 16'($urandom);
    VSR2           = 16'($urandom);
  endtask

  // Drive one cycle of inputs at the falling edge, then settle past the next rise.
  task automatic drive(input logic [15:0] ir, input logic [5:0] ec, input logic [15:0] npc,
                       input logic [15:0] v1, input logic [15:0] v2, input logic en);
    @(negedge clock);
    IR = ir; E_Control = ec; npc_in = npc; VSR1 = v1; VSR2 = v2;
    enable_execute = en;
    W_Control_in = 2'($urandom); Mem_Control_in = 1'($urandom);
    @(posedge clock);
    #2;
  endtask

  initial begin
    reset = 1'b0;
    enable_execute = 1'b1;
    randomize_inputs();
    repeat (2) begin
      @(negedge clock);
      randomize_inputs();
      enable_execute = 1'($urandom);
    end
    @(posedge clock);
    #2;
    chk("reset aluout", aluout, 16'h0000);
    chk("reset IR_Exec", IR_Exec, 16'h0000);
    chk("reset out_valid", 16'(out_valid), 16'h0000);
    @(negedge clock);
    reset = 1'b1;

    // ADD R1,R1,#5 overflowing into the sign bit
    drive(16'h1265, 6'b000000, 16'h0000, 16'h7FFF, 16'h1234, 1'b1);
    chk("add aluout", aluout, 16'h8004);
    chk("add dr", 16'(dr), 16'h0001);
    chk("add NZP", 16'(NZP), 16'h0000);
    chk("add sr1", 16'(sr1), 16'h0001);
    chk("add out_valid", 16'(out_valid), 16'h0001);

    // AND register form, then NOT
    drive(16'h5042, 6'b010001, 16'h0000, 16'hF0F0, 16'h0FF0, 1'b1);
    chk("and aluout", aluout, 16'h00F0);
    drive(16'h907F, 6'b100000, 16'h0000, 16'h00FF, 16'h0000, 1'b1);
    chk("not aluout", aluout, 16'hFF00);

    // BRnz #-2 from npc 3005, and wrap below zero
    drive(16'h0BFE, 6'b000110, 16'h3005, 16'h1111, 16'h2222, 1'b1);
    chk("br pcout", pcout, 16'h3003);
    chk("br aluout", aluout, 16'h3003);
    chk("br NZP", 16'(NZP), 16'h0005);
    chk("br dr", 16'(dr), 16'h0000);
    drive(16'h0BFE, 6'b000110, 16'h0000, 16'h1111, 16'h2222, 1'b1);
    chk("br wrap pcout", pcout, 16'hFFFE);

    // STR R5,R1,#3
    drive(16'h7A43, 6'b001000, 16'h0000, 16'h4000, 16'hBEEF, 1'b1);
    chk("str sr2", 16'(sr2), 16'h0005);
    chk("str pcout", pcout, 16'h4003);
    chk("str M_Data", M_Data, 16'hBEEF);
    chk("str dr", 16'(dr), 16'h0000);

    // Stall holds outputs, then reset beats enable
    drive(16'h1265, 6'b000000, 16'h0000, 16'h7FFF, 16'h0000, 1'b1);
    repeat (3) begin
      drive(16'($urandom), 6'($urandom), 16'($urandom), 16'($urandom), 16'($urandom), 1'b0);
      chk("stall aluout", aluout, 16'h8004);
      chk("stall IR_Exec", IR_Exec, 16'h1265);
      chk("stall out_valid", 16'(out_valid), 16'h0000);
    end
    @(negedge clock);
    reset = 1'b0;
    enable_execute = 1'b1;
    randomize_inputs();
    @(posedge clock);
    #2;
    chk("rst prio aluout", aluout, 16'h0000);
    chk("rst prio out_valid", 16'(out_valid), 16'h0000);
    chk("rst prio M_Data", M_Data, 16'h0000);

    // Randomized traffic with occasional stalls and resets
    for (int i = 0; i < 600; i++) begin
      @(negedge clock);
      randomize_inputs();
      enable_execute = ($urandom_range(0, 3) != 0);
      reset = ($urandom_range(0, 39) != 0);
    end
    @(negedge clock);
    reset = 1'b1;
    enable_execute = 1'b0;
    @(posedge clock);
    #3;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/lc3_execute_stage.md
# lc3_execute_stage

Execute stage of the LC-3 pipeline, directly downstream of decode; consumes the decode bundle (E_Control, W_Control, Mem_Control, IR, npc_out) monitored on the decode_out interface. It computes the ALU result and effective/branch address, and registers results plus forwarded control toward writeback and memory. Register-file read addresses are driven combinationally so operands return in the same cycle.

## Interface
- WIDTH, 16, datapath width; fixed at 16 for LC-3.
- clock  in  1  rising-edge clock.
- reset  in  1  synchronous, active-low reset.
- enable_execute  in  1  register-load enable; 0 holds all registered outputs.
- E_Control  in  6  decode control {alu_control[1:0], pcselect1[1:0], pcselect2, op2select}.
- W_Control_in  in  2  writeback select from decode.
- Mem_Control_in  in  1  memory-access mode from decode.
- IR  in  16  instruction from decode.
- npc_in  in  16  next PC from decode (npc_out).
- VSR1, VSR2  in  16 each  register-file read data for sr1, sr2.
- sr1, sr2  out  3 each  combinational register-file read addresses.
- aluout  out  16  ALU result or computed address.
- pcout  out  16  base + offset address.
- M_Data  out  16  store data.
- dr  out  3  destination register.
- NZP  out  3  branch condition mask.
- IR_Exec  out  16  registered IR.
- W_Control_out  out  2  registered W_Control_in.
- Mem_Control_out  out  1  registered Mem_Control_in.
- out_valid  out  1  high for one cycle after each enabled load.

## Operation
- opcode = IR[15:12]. ALU class: ADD 0001, AND 0101, NOT 1001. Stores: ST 0011, STR 0111, STI 1011. BR 0000, JMP 1100.
- sr1 = IR[8:6]; sr2 = IR[11:9] for stores, else IR[2:0]. Both are combinational on the current IR.
- op2 = op2select ? VSR2 : sext(IR[4:0]).
- alu_control: 00 ADD (VSR1+op2), 01 AND (VSR1&op2), 10 NOT (~VSR1), 11 reserved (result 0).
- offset by pcselect1: 00 sext(IR[10:0]), 01 sext(IR[8:0]), 10 sext(IR[5:0]), 11 zero.
- base = pcselect2 ? npc_in : VSR1. pcout = base + offset.
- aluout = ALU result for ALU-class opcodes, else pcout.
- Arithmetic is 16-bit modulo; carry is discarded. Sign extension replicates the top field bit.
- dr = IR[11:9] for ALU, LD/LDR/LDI/LEA; 0 for stores, BR, JMP.
- NZP = IR[11:9] for BR, 3'b111 for JMP, 3'b000 otherwise.
- M_Data = VSR2, always captured; meaningful only for stores.

## Timing
- Every registered output loads at the posedge where reset=1 and enable_execute=1. Latency is 1 cycle from inputs to outputs.
- enable_execute=0: all registered outputs hold; out_valid=0 on the next cycle.
- reset=0 at a posedge: all registered outputs (aluout, pcout, M_Data, dr, NZP, IR_Exec, W_Control_out, Mem_Control_out, out_valid) become 0. Reset takes precedence over a simultaneous enable.
- Reset asserted mid-stream discards the in-flight result. The first load after release uses the inputs present at that edge.
- sr1/sr2 have no reset and follow IR within the cycle.
- No internal state beyond the output registers. Back-to-back enables give one result per cycle.

## Structure
- Shared package lc3_pkg holds:
  - opcode localparams and the alu_control codes;
  - E_Control field indices;
  - the pcselect1 encodings;
  - a sext16 function.
- The decode stage and its agents reuse the same package.
- One sub-module, lc3_exec_alu, is purely combinational: inputs VSR1, op2, alu_control; output result. The top holds address generation and all registers.

## Test plan
- Reset: hold reset=0 for 2 cycles with random inputs -> all registered outputs 0, out_valid 0.
- ADD imm: IR=16'h1265 (ADD R1,R1,#5), E_Control=6'b000000, VSR1=16'h7FFF, enable=1 -> next cycle aluout=16'h8004, dr=1, NZP=0, sr1=1.
- AND reg and NOT: IR=16'h5042 with VSR1=16'hF0F0, VSR2=16'h0FF0, op2select=1 -> aluout=16'h00F0. Then NOT (alu_control=10), VSR1=16'h00FF -> aluout=16'hFF00.
- BR/LEA address: IR=16'h0BFE (BRnz #-2), pcselect1=01, pcselect2=1, npc_in=16'h3005 -> pcout=aluout=16'h3003, NZP=3'b101, dr=0. The 16'h0000 boundary: npc_in=0, offset -2 -> 16'hFFFE.
- Store: IR=16'h7A43 (STR R5,R1,#3), pcselect1=10, pcselect2=0, VSR1=16'h4000, VSR2=16'hBEEF -> sr2=5, pcout=16'h4003, M_Data=16'hBEEF, dr=0.
- Stall and reset priority: load one result, then enable=0 for 3 cycles with changing inputs -> outputs hold, out_valid=0. Assert reset and enable together -> reset wins.
